vector_lane_loader: RTL
=======================

// Module: vector_lane_loader
// PURPOSE
//  Stage directly upstream of filter_and_select. Collects 64-bit words from the DMA
//  stream into K-lane vectors (K*64 bits) and tags each vector with its precision
//  code. Presents vectors with a valid/ready handshake; m_data feeds filter_and_select
//  data_in, m_data_select feeds data_select.
//  Ping-pong double buffer: one bank fills while the other is held at the output.
// PARAMETERS
//  K          8    lanes per vector, >=1; lane i = m_data[64*i+63:64*i]
//  LANE_W     64   bits per lane/word (fixed, do not change)
// PORTS
//  clk            in   1         clock, rising edge
//  rst            in   1         asynchronous reset, active-high
//  data_precision in   4         thermometer code: 0001=8b 0011=16b 0111=32b 1111=64b 0000=off
//  s_valid        in   1         input word valid
//  s_ready        out  1         input word accepted when s_valid&s_ready
//  s_data         in   64        input word
//  s_last         in   1         last word of vector (early close)
//  m_valid        out  1         output vector valid
//  m_ready        in   1         downstream accepts vector
//  m_data         out  K*64      vector, lane 0 = first word accepted
//  m_data_select  out  4         precision latched for this vector
//  m_lanes        out  clog2(K+1) number of lanes written (1..K)
//  m_last         out  1         vector was closed by s_last
//  err_precision  out  1         sticky: illegal precision code seen
// BEHAVIOUR
//  - Reset: all outputs 0 (s_ready=0, m_valid=0, m_data=0, err_precision=0).
//    Both banks EMPTY, fill pointer = out pointer = bank 0. A reset mid-fill discards partial data.
//  - Per-bank state: EMPTY -> FILLING (first word accepted) -> FULL (K-th word or s_last
//    accepted) -> EMPTY (m_valid&m_ready).
//  - Precision latch: data_precision is sampled on the first word of each vector and
//    held in that bank. Changes mid-vector are ignored until the next vector.
//  - Legal codes are 0001/0011/0111/1111. 0000 means the chain is off:
//    s_ready=0 at vector start, no error.
//    Any other code at vector start: s_ready=0. If s_valid=1, err_precision is set and
//    stays set until rst. A bank already FILLING keeps accepting words regardless of the current code.
//  - s_ready (registered-state based) = fill bank not FULL and (bank FILLING or code legal).
//  - Word n of a vector is written to lane n. On close, lanes n+1..K-1 are zero-padded.
//    m_lanes = words written; m_last = closed by s_last.
//  - s_last on word K is the same as a full close with m_last=1.
//  - Latency: m_valid rises the cycle after the closing word is accepted. The fill pointer
//    toggles on that same edge.
//  - Both banks FULL: s_ready=0 until one drains. A drain and a close in the same
//    cycle are both honoured. Vectors leave strictly in fill order.
//  - m_data, m_data_select, m_lanes and m_last stay stable while m_valid&!m_ready.
//    m_data=0 when m_valid=0.
//  - Throughput: 1 word/cycle sustained if m_ready is high at least once every K cycles.
//    K=1 gives one vector per accepted word.
// TESTING
//  1. K=8, precision 0001, 8 words 64'hCAFECAFECAFECAFE, m_ready=1
//     -> m_valid 1 cycle after 8th accept, m_data={8{CAFE..}}, m_lanes=8,
//        m_data_select=0001, m_last=0.
//  2. Precision 0111, 2 words 64'h0123456789ABCDEF with s_last on 2nd
//     -> lanes 0-1 data, lanes 2-7 zero, m_lanes=2, m_last=1.
//  3. m_ready=0, offer 24 words -> exactly 16 accepted, s_ready=0 after 16th.
//     Release m_ready -> 3 vectors out in order, no word lost or duplicated.
//  4. Precision 0001 to 1111 at word 3 of a vector -> that vector has m_data_select=0001,
//     next vector has 1111.
//  5. Precision 0000 with s_valid=1 -> s_ready=0, err_precision=0.
//     Precision 0101 with s_valid=1 -> s_ready=0, err_precision=1 until rst.
//  6. rst pulsed after 5 words -> m_valid=0 immediately (async).
//     Next 8 words form a fresh vector starting at lane 0, m_lanes=8.

Source files
------------

// File: rtl/vector_lane_loader.sv
`default_nettype none
// ============================================================================
// Module   : vector_lane_loader
// Purpose  : Collects 64-bit words from a DMA stream into K-lane vectors and
//            tags each vector with the precision code latched on its first
//            word. A ping-pong pair of banks lets one vector fill while the
//            other waits at the output for the downstream filter_and_select.
// Ports    : clk, rst           - clock / asynchronous active-high reset
//            data_precision     - thermometer precision code (0000 = off)
//            s_valid/s_ready    - input word handshake
//            s_data, s_last     - input word, early-close marker
//            m_valid/m_ready    - output vector handshake
//            m_data             - K*64-bit vector, lane 0 = first word
//            m_data_select      - precision latched for the vector
//            m_lanes            - number of lanes written (1..K)
//            m_last             - vector was closed by s_last
//            err_precision      - sticky illegal-precision flag
// Revision : 1.0 - initial release
// ============================================================================
module vector_lane_loader #(
    parameter  int K      = 8,
    parameter  int LANE_W = 64,
    localparam int CNT_W  = $clog2(K + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            data_precision,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [LANE_W-1:0]     s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [K*LANE_W-1:0]   m_data,
    output logic [3:0]            m_data_select,
    output logic [CNT_W-1:0]      m_lanes,
    output logic                  m_last,
    output logic                  err_precision
);

    // ------------------------------------------------------------------
    // Per-bank state encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] C_ST_EMPTY   = 2'd0;
    localparam logic [1:0] C_ST_FILLING = 2'd1;
    localparam logic [1:0] C_ST_FULL    = 2'd2;

    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Bank storage
    // ------------------------------------------------------------------
    logic [1:0]          r_state [2];
    logic [K*LANE_W-1:0] r_data  [2];
    logic [3:0]          r_prec  [2];
    logic [CNT_W-1:0]    r_cnt   [2];
    logic                r_last  [2];

    logic                r_fill_ptr;   // bank currently accepting words
    logic                r_out_ptr;    // bank presented at the output
    logic                r_err;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [1:0]          w_fill_state;
    logic [CNT_W-1:0]    w_fill_cnt;
    logic                w_code_legal;
    logic                w_code_off;
    logic                w_accept;
    logic                w_close;
    logic                w_drain;
    logic                w_err_hit;
    logic                w_out_full;
    logic [K*LANE_W-1:0] w_fill_next;

    assign w_fill_state = r_state[r_fill_ptr];
    assign w_fill_cnt   = r_cnt[r_fill_ptr];

    assign w_code_legal = (data_precision == 4'b0001) ||
                          (data_precision == 4'b0011) ||
                          (data_precision == 4'b0111) ||
                          (data_precision == 4'b1111);
    assign w_code_off   = (data_precision == 4'b0000);

    // A bank that has already started a vector keeps accepting words no
    // matter what the precision input does; only a vector start needs a
    // legal code. Gated by rst so the port reads 0 while reset is held.
    assign s_ready = !rst &&
                     (w_fill_state != C_ST_FULL) &&
                     ((w_fill_state == C_ST_FILLING) || w_code_legal);

    assign w_accept = s_valid && s_ready;

    // s_last on word K is simply a full close that also reports m_last.
    assign w_close  = w_accept && (s_last || (w_fill_cnt == C_LAST_IDX));

    // An illegal (non-off) code is only an error when it would start a
    // vector, i.e. the fill bank is idle and a word is being offered.
    assign w_err_hit = s_valid && (w_fill_state == C_ST_EMPTY) &&
                       !w_code_legal && !w_code_off;

    assign w_out_full = (r_state[r_out_ptr] == C_ST_FULL);
    assign m_valid    = w_out_full;
    assign w_drain    = w_out_full && m_ready;

    // Output fields are forced to zero while no vector is presented; while
    // a vector waits they come straight from a bank that cannot change
    // until it is drained, so they stay stable under back-pressure.
    assign m_data        = w_out_full ? r_data[r_out_ptr] : '0;
    assign m_data_select = w_out_full ? r_prec[r_out_ptr] : 4'b0000;
    assign m_lanes       = w_out_full ? r_cnt[r_out_ptr]  : '0;
    assign m_last        = w_out_full && r_last[r_out_ptr];

    assign err_precision = r_err;

    // Next contents of the fill bank when a word is accepted. The first
    // word of a vector starts from an all-zero bank, so lanes that are
    // never written on an early close are already zero-padded.
    always_comb begin
        w_fill_next = (w_fill_state == C_ST_EMPTY) ? '0 : r_data[r_fill_ptr];
        for (int i = 0; i < K; i++) begin
            if (w_fill_cnt == CNT_W'(i)) begin
                w_fill_next[i*LANE_W +: LANE_W] = s_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    // The fill and output banks are always different whenever a word is
    // accepted and a vector drains in the same cycle (drain needs FULL,
    // accept needs not FULL), so both updates can be applied together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= C_ST_EMPTY;
                r_data[b]  <= '0;
                r_prec[b]  <= 4'b0000;
                r_cnt[b]   <= '0;
                r_last[b]  <= 1'b0;
            end
            r_fill_ptr <= 1'b0;
            r_out_ptr  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_err_hit) begin
                r_err <= 1'b1;
            end

            if (w_accept) begin
                r_data[r_fill_ptr] <= w_fill_next;
                r_cnt[r_fill_ptr]  <= w_fill_cnt + C_CNT_ONE;
                if (w_fill_state == C_ST_EMPTY) begin
                    r_prec[r_fill_ptr] <= data_precision;
                end
                if (w_close) begin
                    r_state[r_fill_ptr] <= C_ST_FULL;
                    r_last[r_fill_ptr]  <= s_last;
                    r_fill_ptr          <= ~r_fill_ptr;
                end else begin
                    r_state[r_fill_ptr] <= C_ST_FILLING;
                end
            end

            if (w_drain) begin
                r_state[r_out_ptr] <= C_ST_EMPTY;
                r_cnt[r_out_ptr]   <= '0;
                r_last[r_out_ptr]  <= 1'b0;
                r_out_ptr          <= ~r_out_ptr;
            end
        end
    end

endmodule
`default_nettype wire
